// File: rtl/mult5_pkg.sv
// Shared types for the mult5 arbiter slice: operand/product widths, the
// arbiter FSM encoding, the issue-pipeline slot layout and the product helper.
package mult5_pkg;

    localparam int OPW      = 5;    // operand width
    localparam int PRODW    = 10;   // full product width, 31*31 = 961 fits
    localparam int SLOT_IDW = 3;    // tag field wide enough for up to 8 requesters

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    // One stage of the issue pipeline; a bubble is a slot with valid = 0.
    typedef struct packed {
        logic                valid;
        logic [SLOT_IDW-1:0] id;
        logic [OPW-1:0]      a;
        logic [OPW-1:0]      b;
    } pipe_slot_t;

    // Unsigned full-width product; both operands widen before the multiply
    // so no bits are lost.
    function automatic logic [PRODW-1:0] mul5(input logic [OPW-1:0] a,
                                              input logic [OPW-1:0] b);
        return PRODW'(a) * PRODW'(b);
    endfunction

endpackage

// File: rtl/mult5_rr_pick.sv
// Combinational round-robin picker. The search begins one position after
// `last` and wraps modulo NREQ; the first set request wins. Produces a
// one-hot grant, its index and a flag saying whether anything was granted.
module mult5_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    // Walk the requesters in rotated priority order and keep the first hit.
    always_comb begin
        int              sum;
        logic [IDW-1:0]  idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum = int'(last) + off;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = sum[IDW-1:0];
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult5_share_arb.sv
// Round-robin arbiter sharing one pipelined 5x5 unsigned multiplier among
// NREQ requesters. One operand pair is accepted per cycle, tagged with the
// requester index, and returned as a 10-bit product exactly LAT cycles later.
// The IDLE/ACTIVE/DRAIN FSM gates grants and reports when the datapath has
// emptied. Optional build macro MULT5_ARB_STATS_EN adds per-requester
// saturating grant counters readable through stat_sel/stat_cnt.
module mult5_share_arb
    import mult5_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int LAT  = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [PRODW-1:0]    rsp_product,
    output logic                idle
`ifdef MULT5_ARB_STATS_EN
    ,
    input  logic [IDW-1:0]      stat_sel,
    output logic [15:0]         stat_cnt
`endif
);

    arb_state_t         state_reg;
    logic               idle_reg;
    logic [IDW-1:0]     last_grant_reg;

    logic               grant_en;
    logic [NREQ-1:0]    pick_req;
    logic [NREQ-1:0]    gnt_onehot;
    logic [IDW-1:0]     gnt_idx;
    logic               hs;

    logic [OPW-1:0]     op_a [NREQ];
    logic [OPW-1:0]     op_b [NREQ];

    pipe_slot_t         issue_slot;
    pipe_slot_t         tail_slot;
    logic               slots_busy;
    logic               pipe_empty_next;

    logic               rsp_valid_reg;
    logic [IDW-1:0]     rsp_id_reg;
    logic [PRODW-1:0]   rsp_product_reg;
    logic               unused_tail_id;

    // Unpack the flat operand buses so the granted pair can be muxed by index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_a[gi] = req_a[gi*OPW +: OPW];
        assign op_b[gi] = req_b[gi*OPW +: OPW];
    end

    // Grants only while ACTIVE and still enabled, so a falling enable blocks
    // the grant in that very cycle.
    assign grant_en = (state_reg == ACTIVE) && enable;
    assign pick_req = req_valid & {NREQ{grant_en}};

    mult5_rr_pick #(
        .NREQ   (NREQ)
    ) u_pick (
        .req     (pick_req),
        .last    (last_grant_reg),
        .gnt     (gnt_onehot),
        .gnt_idx (gnt_idx),
        .gnt_any (hs)
    );

    assign req_ready = gnt_onehot;

    // Build the stage-1 entry; a cycle without a handshake becomes a bubble.
    always_comb begin
        issue_slot       = '0;
        issue_slot.valid = hs;
        issue_slot.id    = SLOT_IDW'(gnt_idx);
        issue_slot.a     = op_a[gnt_idx];
        issue_slot.b     = op_b[gnt_idx];
    end

    // Operand slots ahead of the product register. With LAT = 1 the product
    // register takes the issue entry directly.
    if (LAT == 1) begin : g_no_slots
        assign tail_slot  = issue_slot;
        assign slots_busy = 1'b0;
    end else begin : g_slots
        pipe_slot_t        slot_reg [LAT-1];
        logic [LAT-2:0]    slot_valid;

        for (genvar gi = 0; gi < LAT-1; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // First slot captures the issue entry every cycle.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        slot_reg[gi] <= '0;
                    end else begin
                        slot_reg[gi] <= issue_slot;
                    end
                end
            end else begin : g_body
                // Later slots simply shift; the pipeline never stalls.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        slot_reg[gi] <= '0;
                    end else begin
                        slot_reg[gi] <= slot_reg[gi-1];
                    end
                end
            end
            assign slot_valid[gi] = slot_reg[gi].valid;
        end

        assign tail_slot  = slot_reg[LAT-2];
        assign slots_busy = |slot_valid;
    end

    // Everything that will occupy a slot or the product register next cycle
    // is either the issue entry or a current slot; if none is valid the
    // datapath is empty from the next cycle on.
    assign pipe_empty_next = !issue_slot.valid && !slots_busy;

    // FSM with registered idle flag; DRAIN exits to IDLE on the edge after
    // which the datapath holds nothing, so idle rises right after the last
    // result was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idle_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    idle_reg <= !enable;
                    if (enable) begin
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    idle_reg <= 1'b0;
                    if (!enable) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        state_reg <= ACTIVE;
                        idle_reg  <= 1'b0;
                    end else if (pipe_empty_next) begin
                        state_reg <= IDLE;
                        idle_reg  <= 1'b1;
                    end else begin
                        idle_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idle_reg  <= 1'b1;
                end
            endcase
        end
    end

    // Round-robin pointer moves only when a handshake actually happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= IDW'(NREQ - 1);
        end else if (hs) begin
            last_grant_reg <= gnt_idx;
        end
    end

    // Final stage: multiply the oldest operands and register the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_product_reg <= '0;
        end else begin
            rsp_valid_reg <= tail_slot.valid;
            if (tail_slot.valid) begin
                rsp_id_reg      <= tail_slot.id[IDW-1:0];
                rsp_product_reg <= mul5(tail_slot.a, tail_slot.b);
            end
        end
    end

    // The slot tag field is sized for the largest NREQ; upper bits may be spare.
    assign unused_tail_id = ^tail_slot.id;

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_product = rsp_product_reg;
    assign idle        = idle_reg;

`ifdef MULT5_ARB_STATS_EN
    logic [15:0] cnt_reg [NREQ];
    logic [15:0] stat_cnt_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        // Saturating grant counter for requester gi.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg[gi] <= '0;
            end else if (req_valid[gi] && req_ready[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
            end
        end
    end

    // Registered readout of the selected counter; unused selector codes read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_reg <= '0;
        end else if (int'(stat_sel) < NREQ) begin
            stat_cnt_reg <= cnt_reg[stat_sel];
        end else begin
            stat_cnt_reg <= '0;
        end
    end

    assign stat_cnt = stat_cnt_reg;
`endif

endmodule

// File: tb/tb_mult5_share_arb.sv
// Directed bench for mult5_share_arb (NREQ=4, LAT=2). Inputs change and
// outputs are sampled 1-2 ns after the rising edge.
module tb_mult5_share_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_a = '0;
    logic [19:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [9:0]  rsp_product;
    logic        idle;
`ifdef MULT5_ARB_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [15:0] stat_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_last = 3;

    always #5 clk = ~clk;

    mult5_share_arb #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .idle        (idle)
`ifdef MULT5_ARB_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [4:0] a, input logic [4:0] b);
        req_a[5*i +: 5] = a;
        req_b[5*i +: 5] = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; req_valid = '0;
        step(); step();
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got %b want 1", idle); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_product !== 10'd0) begin n_bad++; $display("FAIL reset_rsp_product got %0d want 0", rsp_product); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle got %b want 1", idle); end
        enable = 1'b1; req_valid = 4'b0100; set_op(2, 5'd31, 5'd31);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_no_grant got %b want 0000", req_ready); end
        req_valid = '0;
        step();
        n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL active_idle got %b want 0", idle); end
        $display("reset: checked reset values and IDLE->ACTIVE");
    endtask

    task automatic test_single();
        set_op(2, 5'd31, 5'd31);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
        exp_last = 2;
        step();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early got %b want 0", rsp_valid); end
        step();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_id got %0d want 2", rsp_id); end
        n_cmp++; if (rsp_product !== 10'd961) begin n_bad++; $display("FAIL single_product got %0d want 961", rsp_product); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle got %b want 0", rsp_valid); end
        $display("single: req2 31*31 -> id 2 product 961");
    endtask

    task automatic test_stream();
        logic [3:0] exp_rdy;
        set_op(0, 5'd5, 5'd7);
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 6) ? 4'b0001 : 4'b0000;
            #1;
            exp_rdy = (k < 6) ? 4'b0001 : 4'b0000;
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL stream_ready k=%0d got %b want %b", k, req_ready, exp_rdy); end
            n_cmp++; if (rsp_valid !== (k >= 2)) begin n_bad++; $display("FAIL stream_valid k=%0d got %b want %b", k, rsp_valid, (k >= 2)); end
            if (k >= 2) begin
                n_cmp++; if (rsp_id !== 2'd0 || rsp_product !== 10'd35) begin
                    n_bad++; $display("FAIL stream_rsp k=%0d got id %0d prod %0d want id 0 prod 35", k, rsp_id, rsp_product);
                end
            end
            step();
        end
        exp_last = 0;
        $display("stream: req0 granted 6 cycles in a row, 6 products of 35");
    endtask

    task automatic test_round_robin();
        int gid [8];
        logic [3:0] exp_rdy;
        for (int i = 0; i < 4; i++) set_op(i, 5'(i + 1), 5'd3);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            exp_rdy = 4'b0000;
            if (k < 8) begin
                gid[k]   = (exp_last + 1) % 4;
                exp_last = gid[k];
                exp_rdy  = 4'(1 << gid[k]);
            end
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, exp_rdy); end
            if (k >= 2) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(gid[k-2]) || rsp_product !== 10'((gid[k-2] + 1) * 3)) begin
                    n_bad++; $display("FAIL rr_rsp k=%0d got v%b id %0d prod %0d want v1 id %0d prod %0d",
                                      k, rsp_valid, rsp_id, rsp_product, gid[k-2], (gid[k-2] + 1) * 3);
                end
            end
            step();
        end
        $display("round_robin: 8 grants rotated in index order, responses in issue order");
    endtask

    task automatic test_drain();
        set_op(1, 5'd2, 5'd9); set_op(3, 5'd10, 5'd10);
        req_valid = 4'b0010; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL drain_g1 got %b want 0010", req_ready); end
        step();
        req_valid = 4'b1000; #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL drain_g3 got %b want 1000", req_ready); end
        exp_last = 3;
        step();
        enable = 1'b0; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL drain_fall_grant got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 10'd18) begin
            n_bad++; $display("FAIL drain_rsp1 got v%b id %0d prod %0d want v1 id 1 prod 18", rsp_valid, rsp_id, rsp_product);
        end
        n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL drain_idle_n got %b want 0", idle); end
        step();
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL drain_no_grant got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== 10'd100) begin
            n_bad++; $display("FAIL drain_rsp3 got v%b id %0d prod %0d want v1 id 3 prod 100", rsp_valid, rsp_id, rsp_product);
        end
        n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL drain_idle_n1 got %b want 0", idle); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            n_bad++; $display("FAIL drain_done got v%b idle %b want v0 idle 1", rsp_valid, idle);
        end
        req_valid = '0;
        $display("drain: two in-flight results emitted, no grants, idle at n+LAT");
    endtask

    task automatic test_reenable();
        enable = 1'b1; req_valid = '0;
        step();
        set_op(1, 5'd4, 5'd4);
        req_valid = 4'b0010; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL reen_g1 got %b want 0010", req_ready); end
        exp_last = 1;
        step();
        enable = 1'b0; req_valid = '0;
        step();
        enable = 1'b1; set_op(2, 5'd6, 5'd5); req_valid = 4'b0100; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reen_drain_grant got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_product !== 10'd16 || idle !== 1'b0) begin
            n_bad++; $display("FAIL reen_rsp got v%b prod %0d idle %b want v1 prod 16 idle 0", rsp_valid, rsp_product, idle);
        end
        step();
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL reen_resume got %b want 0100", req_ready); end
        exp_last = 2;
        step();
        req_valid = '0;
        step();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 10'd30) begin
            n_bad++; $display("FAIL reen_rsp2 got v%b id %0d prod %0d want v1 id 2 prod 30", rsp_valid, rsp_id, rsp_product);
        end
        $display("reenable: grants resume the cycle after enable returns in DRAIN");
    endtask

    task automatic test_reset_midflight();
        set_op(2, 5'd3, 5'd3); set_op(3, 5'd7, 5'd7);
        req_valid = 4'b0100; #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL rstmid_g2 got %b want 0100", req_ready); end
        step();
        req_valid = 4'b1000; #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rstmid_g3 got %b want 1000", req_ready); end
        #1;
        rst_n = 1'b0; req_valid = '0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_async got v%b idle %b want v0 idle 1", rsp_valid, idle);
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ghost k=%0d got %b want 0", k, rsp_valid); end
        end
        req_valid = 4'hF; #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid_first got %b want 0001", req_ready); end
        step();
        req_valid = 4'b1110; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rstmid_second got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        step(); step();
        $display("reset_midflight: in-flight ops dropped, first grant to requester 0");
    endtask

`ifdef MULT5_ARB_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0; req_valid = '0; stat_sel = 2'd1;
        step();
        rst_n = 1'b1; enable = 1'b1;
        step();
        set_op(1, 5'd1, 5'd1);
        req_valid = 4'b0010;
        repeat (3) step();
        req_valid = '0;
        step();
        n_cmp++; if (stat_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_three got %0d want 3", stat_cnt); end
        req_valid = 4'b0010;
        repeat (65540) step();
        req_valid = '0;
        step();
        n_cmp++; if (stat_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL stats_sat got %h want ffff", stat_cnt); end
        stat_sel = 2'd0;
        step();
        n_cmp++; if (stat_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_other0 got %0d want 0", stat_cnt); end
        stat_sel = 2'd2;
        step();
        n_cmp++; if (stat_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_other2 got %0d want 0", stat_cnt); end
        $display("stats: requester 1 counter saturated, others untouched");
    endtask
`endif

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_round_robin();
        test_drain();
        test_reenable();
        test_reset_midflight();
`ifdef MULT5_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult5_share_arb.md
# mult5_share_arb

Round-robin arbiter and sequencer that shares one pipelined 5×5-bit unsigned multiplier among `NREQ` requesters. It accepts at most one operand pair per cycle and tags each issued operation with the requester index. It returns the 10-bit product with that tag after a fixed latency. It sits between the requester-side logic and the shared multiplier datapath, and controls enable and drain of the datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 2: multiplier pipeline depth in cycles, ≥1 (2 = registered operands plus registered product).
- `IDW`, $clog2(NREQ): tag width (localparam).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `enable` in 1: 1 allows grants; 0 requests drain.
- `req_valid` in NREQ: per-requester operation pending.
- `req_a` in NREQ*5: operand A, requester i at bits [5i+4:5i].
- `req_b` in NREQ*5: operand B, same packing.
- `req_ready` out NREQ: one-hot grant; the handshake occurs when `req_valid[i]&req_ready[i]`.
- `rsp_valid` out 1: product valid this cycle.
- `rsp_id` out IDW: requester index of the product.
- `rsp_product` out 10: `a*b`, unsigned.
- `idle` out 1: state IDLE and pipeline empty.
- `stat_sel` in IDW: counter select (only with MULT5_ARB_STATS_EN).
- `stat_cnt` out 16: grant count of the selected requester (only with MULT5_ARB_STATS_EN).

## Operation
- FSM states and transitions:
  - IDLE: no grants. Go to ACTIVE when `enable`=1.
  - ACTIVE: grant every cycle any `req_valid` is set. Go to DRAIN when `enable`=0.
  - DRAIN: no grants. Go to IDLE once all LAT pipeline slots are empty. Go to ACTIVE if `enable` returns to 1 before the pipeline is empty.
- Arbitration is combinational round-robin from `req_valid`:
  - Search starts at (last_grant+1) mod NREQ.
  - `last_grant` updates only on a handshake.
  - Reset value of `last_grant` is NREQ-1, so requester 0 has first priority.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - A requester holds `req_valid`, `req_a` and `req_b` stable until its handshake.
- Issue pipeline: each handshake loads {valid=1, id, a, b} into stage 1. Stages advance every cycle. A cycle with no handshake inserts a bubble (valid=0).
- The product is computed full-width 10 bits. Max 31*31=961, so it never overflows.
- The pipeline never stalls. There is no response backpressure; consumers must accept `rsp_valid` unconditionally.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0.
  - `idle`=1, FSM=IDLE.
  - All pipeline valids cleared, `stat_cnt`=0.
- Reset mid-operation discards in-flight operations silently. No `rsp_valid` is emitted for them.
- Boundary cases:
  - `enable` falls in the same cycle as a request: no grant that cycle.
  - Single requester asserting continuously: granted every cycle, 100% throughput.
  - All requesters asserting: each is granted once every NREQ cycles, in index order.

## Timing
- Handshake in cycle n → `rsp_valid`=1 with matching `rsp_id` and `rsp_product` in cycle n+LAT. The result is valid for exactly one cycle.
- Responses return in issue order.
- `req_ready` is combinational from `req_valid`, the FSM state and `last_grant`.
- All other outputs are registered.
- `idle` rises the first cycle after the last in-flight result has been presented while the FSM is in IDLE.
- Best-case ACTIVE→DRAIN→IDLE sequence: `enable` falls in cycle n and the last handshake was in cycle n-1. The last `rsp_valid` is in cycle n-1+LAT, and `idle`=1 from cycle n+LAT.

## Configuration
- `MULT5_ARB_STATS_EN` defined:
  - One 16-bit saturating grant counter per requester. Each counter increments on its requester's handshake and holds at 16'hFFFF.
  - `stat_cnt` = counter[`stat_sel`], registered with 1-cycle latency.
- Undefined: no counters, and the `stat_sel`/`stat_cnt` ports are absent.

## Structure
- Package `mult5_pkg`:
  - `OPW`=5, `PRODW`=10.
  - FSM enum `arb_state_t` {IDLE, ACTIVE, DRAIN}.
  - Pipeline slot struct {valid, id, a, b}.
- Sub-module `mult5_rr_pick`: combinational round-robin one-hot picker, (req vector, last index) → (grant one-hot, grant index).
- The multiplier pipeline and FSM live in the top module.

## Test plan
- Reset with all requests idle → after reset `idle`=1, `req_ready`=0, `rsp_valid`=0. Then `enable`=1 → state ACTIVE.
- Requester 2 only, a=31, b=31, LAT=2, handshake in cycle 5 → cycle 7: `rsp_valid`=1, `rsp_id`=2, `rsp_product`=961.
- All 4 requesters continuously valid, a=i+1, b=3 → grant order 0,1,2,3,0… One response per cycle with products 3,6,9,12 in that order.
- `enable` dropped while 2 operations are in flight → both responses emitted, no new grants, then `idle`=1. Re-enable during DRAIN → grants resume the next cycle.
- `rst_n` pulsed low while 2 operations are in flight → no `rsp_valid` afterwards. The first post-reset grant goes to requester 0.
- With MULT5_ARB_STATS_EN: requester 1 granted 70000 times → `stat_cnt` (sel=1) = 16'hFFFF, and other counters stay unaffected.
